// File: rtl/seq_010_gen_pkg.sv
// ---------------------------------------------------------------------------
// seq_010_gen_pkg
//   Shared definitions for the "010" stimulus generator: the generator state
//   enum, the serial-line idle level and the three-bit pattern it emits.
//   PATTERN is sent MSB first, so bit 2 goes out on the line first.
// ---------------------------------------------------------------------------
package seq_010_gen_pkg;

  typedef enum logic [2:0] {
    G_IDLE = 3'd0,
    G_B0   = 3'd1,
    G_B1   = 3'd2,
    G_B2   = 3'd3,
    G_GAP  = 3'd4,
    G_DONE = 3'd5
  } gen_state_e;

  localparam logic       X_IDLE  = 1'b1;
  localparam logic [2:0] PATTERN = 3'b010;

endpackage

// File: rtl/seq_010_gen.sv
// ---------------------------------------------------------------------------
// seq_010_gen
//   Serial stimulus generator for the "010" sequence detector. When start is
//   accepted it sends num copies of "010" on x, separated by gap idle '1'
//   bits, then pulses done for one cycle. sent_count reports how many
//   patterns were completed, to be compared against the detector's count.
//
// Ports
//   clk        : system clock, rising edge
//   rst        : asynchronous active-high reset
//   start      : burst request, sampled only while idle
//   num        : number of patterns to send, latched on accepted start
//   gap        : idle '1' bits between patterns, latched on accepted start
//   x          : serial line to the detector, idles at '1'
//   busy       : high in every state except idle
//   done       : one-cycle pulse at the end of a burst
//   sent_count : patterns fully sent in the current or last burst
// ---------------------------------------------------------------------------
module seq_010_gen
  import seq_010_gen_pkg::*;
#(
  parameter int CNT_W = 10,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num,
  input  logic [GAP_W-1:0] gap,
  output logic             x,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sent_count
);

  gen_state_e       state;
  logic [CNT_W-1:0] num_q;
  logic [GAP_W-1:0] gap_q;
  logic [GAP_W-1:0] gap_cnt;
  logic [CNT_W-1:0] sent_next;

  // sent_count never exceeds num_q, so this increment cannot wrap in use.
  assign sent_next = sent_count + CNT_W'(1);

  // Outputs are registered alongside the state: every branch that picks the
  // next state also loads the Moore outputs belonging to that state, so x,
  // busy and done always match the registered state with no decode delay.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= G_IDLE;
      num_q      <= '0;
      gap_q      <= '0;
      gap_cnt    <= '0;
      sent_count <= '0;
      x          <= X_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        G_IDLE: begin
          if (start) begin
            num_q      <= num;
            gap_q      <= gap;
            sent_count <= '0;
            busy       <= 1'b1;
            if (num == '0) begin
              state <= G_DONE;
              done  <= 1'b1;
              x     <= X_IDLE;
            end else begin
              state <= G_B0;
              x     <= PATTERN[2];
            end
          end
        end

        G_B0: begin
          state <= G_B1;
          x     <= PATTERN[1];
        end

        G_B1: begin
          state <= G_B2;
          x     <= PATTERN[0];
        end

        G_B2: begin
          sent_count <= sent_next;
          if (sent_next == num_q) begin
            state <= G_DONE;
            done  <= 1'b1;
            x     <= X_IDLE;
          end else if (gap_q != '0) begin
            state   <= G_GAP;
            gap_cnt <= gap_q;
            x       <= X_IDLE;
          end else begin
            state <= G_B0;
            x     <= PATTERN[2];
          end
        end

        // gap_cnt enters loaded with gap_q; leaving when it reads 1 gives
        // exactly gap_q cycles in this state.
        G_GAP: begin
          gap_cnt <= gap_cnt - GAP_W'(1);
          if (gap_cnt == GAP_W'(1)) begin
            state <= G_B0;
            x     <= PATTERN[2];
          end
        end

        G_DONE: begin
          state <= G_IDLE;
          busy  <= 1'b0;
          x     <= X_IDLE;
        end

        default: begin
          state <= G_IDLE;
          busy  <= 1'b0;
          x     <= X_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_010_gen.sv
// ---------------------------------------------------------------------------
// tb_seq_010_gen
//   Self-checking bench for seq_010_gen. Expected serial bits and pattern
//   counts are pushed to scoreboard queues when a burst is requested and
//   popped as the generator produces them. A non-overlapping "010" detector
//   model watches x so its count delta can be compared with sent_count.
// ---------------------------------------------------------------------------
module tb_seq_010_gen;

  localparam int CNT_W = 10;
  localparam int GAP_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] num;
  logic [GAP_W-1:0] gap;
  logic             x;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] sent_count;

  int checks = 0;
  int fails  = 0;

  int det_count = 0;
  int det_state = 0;
  bit idle_mon_en = 1'b0;

  bit exp_x_q[$];
  int exp_cnt_q[$];

  always #5 clk = ~clk;

  seq_010_gen #(
    .CNT_W(CNT_W),
    .GAP_W(GAP_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .num       (num),
    .gap       (gap),
    .x         (x),
    .busy      (busy),
    .done      (done),
    .sent_count(sent_count)
  );

  // Non-overlapping "010" detector model sampling x mid-cycle.
  always @(negedge clk or posedge rst) begin
    if (rst) begin
      det_state <= 0;
    end else begin
      case (det_state)
        0: if (x === 1'b0) det_state <= 1;
        1: if (x === 1'b1) det_state <= 2;
        default: begin
          if (x === 1'b0) det_count <= det_count + 1;
          det_state <= 0;
        end
      endcase
    end
  end

  // The line must sit at the idle level whenever the generator is not busy.
  always @(negedge clk) begin
    if (idle_mon_en && rst === 1'b0 && busy === 1'b0) begin
      checks++;
      if (x !== 1'b1) begin
        fails++;
        $display("[TB] FAIL idle_level: x=%b required 1 at %0t", x, $time);
      end
    end
  end

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    num   = '0;
    gap   = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({x, busy, done} !== 3'b100 || sent_count !== '0) begin
      fails++;
      $display("[TB] FAIL reset_values: x=%b busy=%b done=%b cnt=%0d required x=1 busy=0 done=0 cnt=0",
               x, busy, done, sent_count);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({x, busy, done} !== 3'b100) begin
      fails++;
      $display("[TB] FAIL idle_after_reset: x=%b busy=%b done=%b required 1 0 0", x, busy, done);
    end
  endtask

  // Requests one burst and checks it bit by bit against the scoreboard.
  // restart_at >= 0 re-asserts start with other values at that burst cycle.
  task automatic run_burst(input int n, input int g, input int restart_at, input string tag);
    int  det_base;
    int  cyc;
    int  budget;
    int  exp_cnt;
    bit  seen_done;
    bit  e;

    exp_x_q.delete();
    for (int p = 0; p < n; p++) begin
      if (p > 0) for (int i = 0; i < g; i++) exp_x_q.push_back(1'b1);
      exp_x_q.push_back(1'b0);
      exp_x_q.push_back(1'b1);
      exp_x_q.push_back(1'b0);
    end
    exp_cnt_q.push_back(n);

    det_base = det_count;
    budget   = 3 * n + g * n + 20;
    start    = 1'b1;
    num      = CNT_W'(n);
    gap      = GAP_W'(g);
    @(negedge clk);
    start = 1'b0;
    num   = CNT_W'($urandom_range(1023, 0));
    gap   = GAP_W'($urandom_range(15, 0));

    seen_done = 1'b0;
    cyc       = 0;
    while (!seen_done && cyc < budget) begin
      if (cyc == restart_at) begin
        start = 1'b1;
        num   = CNT_W'($urandom_range(20, 1));
        gap   = GAP_W'($urandom_range(15, 0));
      end else begin
        start = 1'b0;
      end
      if (done === 1'b1) begin
        seen_done = 1'b1;
        checks++;
        if (exp_x_q.size() != 0 || x !== 1'b1 || busy !== 1'b1) begin
          fails++;
          $display("[TB] FAIL %s done_cycle: bits_left=%0d x=%b busy=%b required bits_left=0 x=1 busy=1",
                   tag, exp_x_q.size(), x, busy);
        end
      end else begin
        checks++;
        if (exp_x_q.size() == 0) begin
          fails++;
          $display("[TB] FAIL %s done_late: done=%b at cycle %0d required 1", tag, done, cyc);
        end else begin
          e = exp_x_q.pop_front();
          if (x !== e || busy !== 1'b1) begin
            fails++;
            $display("[TB] FAIL %s x_bit%0d: x=%b busy=%b required x=%b busy=1", tag, cyc, x, busy, e);
          end
        end
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;

    if (!seen_done) begin
      checks++;
      fails++;
      $display("[TB] FAIL %s timeout: no done within %0d cycles", tag, budget);
    end

    exp_cnt = exp_cnt_q.pop_front();
    checks++;
    if (sent_count !== CNT_W'(exp_cnt)) begin
      fails++;
      $display("[TB] FAIL %s sent_count: got %0d required %0d", tag, sent_count, exp_cnt);
    end
    checks++;
    if (det_count - det_base != exp_cnt) begin
      fails++;
      $display("[TB] FAIL %s detector_delta: got %0d required %0d", tag, det_count - det_base, exp_cnt);
    end

    if (seen_done) begin
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || sent_count !== CNT_W'(exp_cnt)) begin
        fails++;
        $display("[TB] FAIL %s after_done: done=%b busy=%b cnt=%0d required 0 0 %0d",
                 tag, done, busy, sent_count, exp_cnt);
      end
    end
  endtask

  task automatic test_back_to_back();
    run_burst(3, 0, -1, "back_to_back");
  endtask

  task automatic test_gap();
    run_burst(2, 2, -1, "gap2");
    run_burst(4, 1, -1, "gap1");
    run_burst(2, 15, -1, "gap15");
  endtask

  task automatic test_zero_num();
    run_burst(0, 5, -1, "num0");
  endtask

  task automatic test_single();
    run_burst(1, 15, -1, "num1");
  endtask

  task automatic test_restart_ignored();
    run_burst(4, 3, 2, "restart_ignored");
  endtask

  task automatic test_max_num();
    run_burst(1023, 0, -1, "num_max");
  endtask

  task automatic test_reset_mid_burst();
    start = 1'b1;
    num   = CNT_W'(5);
    gap   = GAP_W'(0);
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (x !== 1'b0) begin
      fails++;
      $display("[TB] FAIL rst_mid_b0: x=%b required 0", x);
    end
    @(negedge clk);
    checks++;
    if (x !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("[TB] FAIL rst_mid_b1: x=%b busy=%b required 1 1", x, busy);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (x !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || sent_count !== '0) begin
      fails++;
      $display("[TB] FAIL rst_mid_abort: x=%b busy=%b done=%b cnt=%0d required 1 0 0 0",
               x, busy, done, sent_count);
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        fails++;
        $display("[TB] FAIL rst_mid_quiet%0d: done=%b busy=%b required 0 0", i, done, busy);
      end
    end
  endtask

  task automatic test_random();
    for (int b = 0; b < 200; b++) begin
      run_burst(int'($urandom_range(20, 0)), int'($urandom_range(15, 0)), -1, "random");
    end
  endtask

  initial begin
    test_reset();
    idle_mon_en = 1'b1;
    test_back_to_back();
    test_gap();
    test_zero_num();
    test_single();
    test_restart_ignored();
    test_reset_mid_burst();
    test_max_num();
    test_random();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/seq_010_gen.md
# seq_010_gen

Serial stimulus generator for the "010" sequence-detector path. On a start request it emits a programmed number of "010" patterns on a single-bit serial line, separated by a programmable run of idle '1' bits. It also reports how many patterns it has sent, so the result can be compared directly against the detector's occurrence count. It drives the detector's `x` input and is the transmit-side counterpart of that detector.

## Interface
- `CNT_W`, default 10: width of the pattern-count request and `sent_count`; matches the detector's count width.
- `GAP_W`, default 4: width of the inter-pattern gap length.
- `clk`  input  1  system clock; all state changes on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `start`  input  1  request to begin a burst; sampled only in `G_IDLE`.
- `num`  input  CNT_W  number of "010" patterns to send; latched when `start` is accepted.
- `gap`  input  GAP_W  number of '1' bits between consecutive patterns; latched when `start` is accepted.
- `x`  output  1  serial line to the detector; idle level is '1'.
- `busy`  output  1  high from the cycle after `start` is accepted until `done` is deasserted.
- `done`  output  1  one-cycle pulse marking the end of a burst.
- `sent_count`  output  CNT_W  patterns fully sent in the current or last burst.

## Operation
- States: `G_IDLE`, `G_B0`, `G_B1`, `G_B2`, `G_GAP`, `G_DONE`.
- Moore outputs decoded from the registered state:
  - `G_B0` → `x`=0; `G_B1` → `x`=1; `G_B2` → `x`=0; all other states → `x`=1.
  - `busy` is high in every state except `G_IDLE`.
  - `done` is high only in `G_DONE`.
- Transitions:
  - `G_IDLE`: `start`=1 latches `num` and `gap` and clears `sent_count` to 0. Next state is `G_B0`, or `G_DONE` if `num`=0. With `start`=0, stay in `G_IDLE`.
  - `G_B0` → `G_B1` → `G_B2`, unconditionally.
  - `G_B2`: `sent_count` increments by 1. If this was the last pattern (`sent_count`+1 == latched `num`), go to `G_DONE`. Otherwise go to `G_GAP` if latched `gap` > 0, else `G_B0`.
  - `G_GAP`: a down-counter loaded with `gap` runs for exactly `gap` cycles, then goes to `G_B0`.
  - `G_DONE` → `G_IDLE`, unconditionally.
- A burst has no leading gap. Back-to-back patterns (`gap`=0) form "010010…", which the detector counts once per pattern. This gives the invariant: detector count delta == `sent_count`.
- `start` asserted while `busy` is ignored. Changes to `num` and `gap` during a burst have no effect.
- `sent_count` holds its final value after `done` and is cleared only when the next `start` is accepted.
- Arithmetic: the remaining-pattern compare uses CNT_W-bit unsigned values. `num` = 2^CNT_W−1 is legal, and `sent_count` never wraps.

## Timing
- Reset values: state `G_IDLE`, `x`=1, `busy`=0, `done`=0, `sent_count`=0, gap counter 0.
- Reset mid-burst aborts immediately. There is no `done` pulse, and `sent_count` reads 0.
- If `start` is sampled at edge k, `x`=0 (first bit) appears in cycle k+1.
- Burst length from the first bit to the last bit is 3·N + G·(N−1) cycles. `done` is high in the following cycle, and `start` is accepted again the cycle after that.
- `num`=0: `done` is high in cycle k+1, `x` stays 1, and `busy` is high for that single cycle.
- `sent_count` updates on the edge that leaves `G_B2`.

## Structure
- Shared package (alongside the detector's package) holds:
  - `gen_state_e`, the enum of the six states.
  - Constants `X_IDLE`=1'b1 and `PATTERN`=3'b010.
- Single module, no sub-modules. The gap down-counter and the pattern counter are inline registers.

## Test plan
- Reset during `G_B1` of a 5-pattern burst → next cycle `x`=1, `busy`=0, `sent_count`=0, no `done` pulse.
- `start` with `num`=3, `gap`=0 → `x` = 0,1,0,0,1,0,0,1,0 over 9 cycles, then `done`=1 for one cycle, `sent_count`=3. A detector instance reports count 3.
- `start` with `num`=2, `gap`=2 → `x` = 0,1,0,1,1,0,1,0, then `done`, `sent_count`=2.
- `start` with `num`=0 → `done` in cycle k+1, `x` constant 1, `sent_count`=0.
- `start` re-asserted mid-burst with different `num` and `gap` → ignored. The burst completes with the originally latched values.
- 200 random bursts (`num` 0–20, `gap` 0–15) chained to the detector → after every `done`, detector count delta equals `sent_count`, and `x`=1 whenever `busy`=0.
